fiapp_pipe: RTL
===============

Name: fiapp_pipe

Overview:
- Parametrised successor of the single-bit fault-injection demo pipeline.
- WIDTH-bit data path, DEPTH-stage register chain with an enable-gated first stage and a registered inverted tap.
- Adds a handshake-driven fault-injection engine: one pipeline stage is corrupted by a masked flip, stuck-at-0 or stuck-at-1 for a programmed window, after a programmed delay.
- Sits in the fault-injection example designs as the observable target for system-observability (signal-of-interest) experiments.

Parameters:
- WIDTH, 8, data width of every stage.
- DEPTH, 3, number of pipeline stages; legal range 2..16.
- CNT_W, 8, width of the delay, length and completed-injection counters.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  WIDTH  pipeline input data.
- enable  in  1  stage-0 load enable.
- o_first  out  WIDTH  stage 0 contents.
- o_last  out  WIDTH  stage DEPTH-1 contents.
- o_inv  out  WIDTH  registered bitwise inverse of stage 0.
- inj_valid  in  1  injection request valid.
- inj_ready  out  1  engine can accept a request.
- inj_stage  in  clog2(DEPTH)  target stage index.
- inj_mode  in  2  00 flip, 01 stuck-0, 10 stuck-1, 11 illegal.
- inj_mask  in  WIDTH  bits affected.
- inj_delay  in  CNT_W  cycles from acceptance to window start.
- inj_len  in  CNT_W  window length in cycles; 0 is treated as 1.
- inj_active  out  1  corruption window in progress.
- inj_done  out  1  one-cycle completion pulse.
- inj_err  out  1  one-cycle pulse, coincident with inj_done, for an illegal request.
- inj_count  out  CNT_W  completed legal injections; saturates at all-ones.

Behaviour:
- Reset (reset low, asynchronous):
  - All stages, o_inv and inj_count are 0.
  - FSM is IDLE; inj_ready=1; inj_active, inj_done and inj_err are 0.
  - Reset asserted mid-window aborts the injection immediately; no done pulse and no count increment.
- Pipeline next-state, before fault:
  - s0 = enable ? a : s0.
  - sk = s(k-1) for k = 1..DEPTH-1.
  - o_inv register <= ~s0 (current value).
- Latency: a reaches o_first 1 edge after enable; o_last after DEPTH edges; o_inv after 2 edges.
- Fault application: while FSM is ACTIVE, the next-state of stage inj_stage (latched copy) is modified before registering.
  - Flip: d ^ mask.
  - Stuck-0: d & ~mask.
  - Stuck-1: d | mask.
  - With enable=0 on stage 0, the held value is corrupted, so flip toggles every window cycle.
  - Other stages are unaffected; corrupted data propagates normally.
- FSM states: IDLE, ARMED, ACTIVE, DONE.
  - IDLE: inj_ready=1.
    - Request accepted on an edge E0 with inj_valid & inj_ready; stage, mode, mask, delay and len are latched.
    - Illegal request (mode 11 or inj_stage >= DEPTH): go to DONE with err flagged.
    - Legal request, delay=0: go to ACTIVE.
    - Legal request, delay>0: go to ARMED.
  - ARMED: counter loaded with delay, decrements each edge; goes to ACTIVE on the edge where counter==1.
  - ACTIVE: inj_active=1; lasts max(len,1) cycles, then goes to DONE.
    - Corrupted updates occur at edges E(d+1)..E(d+len).
  - DONE: inj_done=1 for one cycle; inj_err=1 if the request was illegal; then returns to IDLE.
    - inj_count increments (saturating) on legal completion only.
  - inj_ready=0 in ARMED, ACTIVE and DONE; inj_valid is ignored there (no queueing).
- Back-to-back: a new request is accepted on the edge after the DONE cycle at the earliest.
- Request fields are sampled only at acceptance; later changes have no effect.
- inj_count at all-ones stays all-ones.

Test Plan:
1. WIDTH=8, DEPTH=3, reset released, a=0x5A, enable=1 -> o_first=0x5A after 1 edge, o_inv=0xA5 after 2, o_last=0x5A after 3. Then enable=0, a=0xFF -> all outputs hold.
2. Steady a=0x5A; inject flip, stage 0, mask 0x0F, delay 0, len 2 -> o_first=0x55 for exactly 2 cycles then 0x5A; o_last shows 0x55 for 2 cycles, 2 edges later; inj_active high 2 cycles; inj_done pulses once; inj_count=1.
3. Stuck-1, stage 2, mask 0x80, delay 3, len 4, a=0x00 -> inj_ready low from acceptance; o_last=0x80 for 4 cycles starting 4 edges after acceptance; stages 0 and 1 stay 0x00.
4. Mode 11 request, then separately inj_stage=3 with DEPTH=3 -> each gives inj_done and inj_err high the cycle after acceptance; no data corruption; inj_count unchanged.
5. Reset asserted during ACTIVE -> outputs 0 asynchronously, FSM IDLE, inj_ready=1, no inj_done; a fresh request afterwards completes normally.
6. CNT_W=2, issue 4 legal injections -> inj_count reads 1, 2, 3, 3; inj_valid held high while busy is ignored until IDLE.

Source files
------------

// File: rtl/fiapp_pipe.sv
// fiapp_pipe: WIDTH-bit, DEPTH-stage register pipeline with a registered
// inverted tap of stage 0 and a handshake-driven fault-injection engine that
// corrupts one stage (flip / stuck-0 / stuck-1 under a mask) for a programmed
// window after a programmed delay.
module fiapp_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         a,
    input  logic                     enable,
    output logic [WIDTH-1:0]         o_first,
    output logic [WIDTH-1:0]         o_last,
    output logic [WIDTH-1:0]         o_inv,
    input  logic                     inj_valid,
    output logic                     inj_ready,
    input  logic [$clog2(DEPTH)-1:0] inj_stage,
    input  logic [1:0]               inj_mode,
    input  logic [WIDTH-1:0]         inj_mask,
    input  logic [CNT_W-1:0]         inj_delay,
    input  logic [CNT_W-1:0]         inj_len,
    output logic                     inj_active,
    output logic                     inj_done,
    output logic                     inj_err,
    output logic [CNT_W-1:0]         inj_count
);

    localparam int unsigned SW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_s [DEPTH];
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [WIDTH-1:0] r_inv;

    logic [SW-1:0]    r_tgt;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic             w_accept;
    logic             w_illegal;
    logic [CNT_W-1:0] w_req_len;

    function automatic logic [WIDTH-1:0] f_fault(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] mask
    );
        case (mode)
            2'b00:   return d ^ mask;
            2'b01:   return d & ~mask;
            2'b10:   return d | mask;
            default: return d;
        endcase
    endfunction

    assign w_accept  = inj_valid && (r_state == IDLE);
    assign w_illegal = (inj_mode == 2'b11) || (32'(inj_stage) >= DEPTH);
    assign w_req_len = (inj_len == '0) ? CNT_W'(1) : inj_len;

    // Per-stage next-state; the latched target stage is corrupted while ACTIVE.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] w_pre;
        if (k == 0) begin : g_head
            assign w_pre = enable ? a : r_s[0];
        end else begin : g_body
            assign w_pre = r_s[k-1];
        end
        assign w_d[k] = ((r_state == ACTIVE) && (r_tgt == SW'(k)))
                        ? f_fault(w_pre, r_mode, r_mask) : w_pre;
    end

    // Pipeline stages and the inverted tap of stage 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) r_s[k] <= '0;
            r_inv <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) r_s[k] <= w_d[k];
            r_inv <= ~r_s[0];
        end
    end

    // Injection FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Injection FSM next-state and handshake/status outputs.
    always_comb begin
        w_next     = r_state;
        inj_ready  = 1'b0;
        inj_active = 1'b0;
        inj_done   = 1'b0;
        inj_err    = 1'b0;
        case (r_state)
            IDLE: begin
                inj_ready = 1'b1;
                if (w_accept) begin
                    if (w_illegal)              w_next = DONE;
                    else if (inj_delay == '0)   w_next = ACTIVE;
                    else                        w_next = ARMED;
                end
            end
            ARMED: begin
                if (r_cnt == CNT_W'(1)) w_next = ACTIVE;
            end
            ACTIVE: begin
                inj_active = 1'b1;
                if (r_cnt == CNT_W'(1)) w_next = DONE;
            end
            DONE: begin
                inj_done = 1'b1;
                inj_err  = r_err;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, shared delay/length counter and completed-injection count.
    // One counter serves both ARMED (delay) and ACTIVE (length); it is reloaded
    // with the window length on the ARMED->ACTIVE edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tgt   <= '0;
            r_mode  <= '0;
            r_mask  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tgt  <= inj_stage;
                        r_mode <= inj_mode;
                        r_mask <= inj_mask;
                        r_len  <= w_req_len;
                        r_err  <= w_illegal;
                        r_cnt  <= (inj_delay != '0) ? inj_delay : w_req_len;
                    end
                end
                ARMED:  r_cnt <= (r_cnt == CNT_W'(1)) ? r_len : r_cnt - 1'b1;
                ACTIVE: r_cnt <= r_cnt - 1'b1;
                DONE: begin
                    if (!r_err && (r_count != '1)) r_count <= r_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_first   = r_s[0];
    assign o_last    = r_s[DEPTH-1];
    assign o_inv     = r_inv;
    assign inj_count = r_count;

endmodule
